// File: rtl/aes_img_pkg.sv
// Shared definitions for the encrypted-image path: block geometry, sequencer
// state encoding and the byte-select helper also used by the AES core.
package aes_img_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;

    typedef logic [BLOCK_W-1:0] aes_block_t;
    typedef logic [2:0]         seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_FETCH = 3'd1;
    localparam seq_state_t ST_ISSUE = 3'd2;
    localparam seq_state_t ST_WAIT  = 3'd3;
    localparam seq_state_t ST_DRAIN = 3'd4;
    localparam seq_state_t ST_DONE  = 3'd5;

    // Byte idx of a block, byte 0 being the most significant one.
    function automatic logic [7:0] block_byte(input aes_block_t blk, input logic [3:0] idx);
        aes_block_t shifted;
        shifted = blk << {idx, 3'b000};
        return shifted[BLOCK_W-1 -: 8];
    endfunction

endpackage

// File: rtl/rom_block_fetcher.sv
// Reads 16 consecutive ROM bytes starting at base and packs them MSB-first
// into one 128-bit block; block_valid marks the cycle the last byte lands.
module rom_block_fetcher
    import aes_img_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output aes_block_t        block,
    output logic              block_valid
);

    logic               issuing;
    logic [3:0]         issue_idx;
    logic [ROM_LAT-1:0] data_vld;
    logic [3:0]         cap_idx;
    logic               capture;

    // Each issued address comes back as data ROM_LAT cycles later.
    assign capture     = data_vld[ROM_LAT-1];
    assign block_valid = capture && (cap_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_addr  <= '0;
            issuing   <= 1'b0;
            issue_idx <= '0;
            data_vld  <= '0;
            cap_idx   <= '0;
            block     <= '0;
        end else begin
            if (go) begin
                rom_addr  <= base;
                issuing   <= 1'b1;
                issue_idx <= '0;
            end else if (issuing) begin
                if (issue_idx == 4'd15) begin
                    issuing <= 1'b0;
                end else begin
                    rom_addr  <= rom_addr + ADDR_W'(1);
                    issue_idx <= issue_idx + 4'd1;
                end
            end

            data_vld[0] <= issuing;
            for (int i = 1; i < ROM_LAT; i++) begin
                data_vld[i] <= data_vld[i-1];
            end

            if (go) begin
                cap_idx <= '0;
            end else if (capture) begin
                cap_idx <= cap_idx + 4'd1;
            end

            if (capture) begin
                block <= {block[BLOCK_W-9:0], rom_data};
            end
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Moves the encrypted image ROM -> AES decryption core -> decryption frame
// memory one 16-byte block at a time, with a single block in flight.
module aes_block_sequencer
    import aes_img_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int NUM_BYTES = 19200,
    parameter int ROM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              aes_in_valid,
    input  logic              aes_in_ready,
    output aes_block_t        aes_in_block,
    input  logic              aes_out_valid,
    output logic              aes_out_ready,
    input  aes_block_t        aes_out_block,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-5:0] block_count
);

    localparam int               CNT_W    = ADDR_W - 4;
    localparam logic [ADDR_W:0]  LAST_END = (ADDR_W+1)'(NUM_BYTES);

    if (NUM_BYTES % BLOCK_BYTES != 0) begin : g_bad_num_bytes
        $error("aes_block_sequencer: NUM_BYTES must be a multiple of 16");
    end
    if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_bad_rom_lat
        $error("aes_block_sequencer: ROM_LAT must be 1 or 2");
    end

    seq_state_t        state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] fetch_base;
    logic [3:0]        drain_idx;
    aes_block_t        plain;
    logic              accept_start;
    logic              last_write;
    logic              pass_end;
    logic              fetch_go;
    logic              block_valid;

    assign next_base    = base + ADDR_W'(BLOCK_BYTES);
    assign pass_end     = ({1'b0, base} + (ADDR_W+1)'(BLOCK_BYTES)) == LAST_END;
    assign accept_start = start && (state == ST_IDLE || state == ST_DONE);
    assign last_write   = (state == ST_DRAIN) && (drain_idx == 4'd15);
    assign fetch_go     = accept_start || (last_write && !pass_end);
    assign fetch_base   = accept_start ? '0 : next_base;

    rom_block_fetcher #(
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) u_fetcher (
        .clk         (clk),
        .rst         (rst),
        .go          (fetch_go),
        .base        (fetch_base),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .block       (aes_in_block),
        .block_valid (block_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            base        <= '0;
            drain_idx   <= '0;
            block_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_FETCH;
                        base        <= '0;
                        block_count <= '0;
                    end
                end
                ST_FETCH: begin
                    if (block_valid) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (aes_in_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_out_valid) begin
                        state     <= ST_DRAIN;
                        drain_idx <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_idx <= drain_idx + 4'd1;
                    if (drain_idx == 4'd15) begin
                        block_count <= block_count + CNT_W'(1);
                        base        <= next_base;
                        state       <= pass_end ? ST_DONE : ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: plain is pure datapath with no reset; every consumer is gated by
    // the DRAIN state, so its post-reset contents are never observed.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT && aes_out_valid) begin
            plain <= aes_out_block;
        end
    end

    assign aes_in_valid  = (state == ST_ISSUE);
    assign aes_out_ready = (state == ST_WAIT);
    assign mem_we        = (state == ST_DRAIN);
    assign mem_addr      = mem_we ? base + {{(ADDR_W-4){1'b0}}, drain_idx} : '0;
    assign mem_din       = mem_we ? block_byte(plain, drain_idx) : 8'h00;
    assign busy          = (state != ST_IDLE) && (state != ST_DONE);
    assign done          = (state == ST_DONE);

endmodule

// File: doc/aes_block_sequencer.md
# aes_block_sequencer

Streams the encrypted image out of the synchronous image ROM 16 bytes at a time and packs each group into a 128-bit AES block. It hands each block to the AES decryption core over a valid/ready handshake, then writes the 16 returned plaintext bytes into port A of the decryption frame memory that the VGA sprite path reads. It sits between the encrypted-image ROM and the decryption memory, and replaces the byte-serial decrypter path.

## Interface
Parameters:
- ADDR_W, 15, byte address width of the ROM and the decryption memory
- NUM_BYTES, 19200, image size in bytes; must be a multiple of 16 (elaboration error otherwise)
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous and active-low
- start  in  1  one-cycle pulse that begins a full-image pass
- rom_addr  out  ADDR_W  encrypted ROM read address
- rom_data  in  8  ROM data, valid ROM_LAT cycles after rom_addr
- aes_in_valid  out  1  block offered to the AES core
- aes_in_ready  in  1  AES core accepts the block
- aes_in_block  out  128  ciphertext block; byte 0 in bits [127:120]
- aes_out_valid  in  1  plaintext block available
- aes_out_ready  out  1  sequencer accepts plaintext
- aes_out_block  in  128  plaintext block; byte 0 in bits [127:120]
- mem_addr  out  ADDR_W  decryption memory write address
- mem_din  out  8  write data
- mem_we  out  1  write enable
- busy  out  1  high from the cycle after an accepted start until DONE is entered
- done  out  1  sticky completion flag; cleared by the next accepted start
- block_count  out  ADDR_W-4  number of blocks fully written in this pass

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE.
- IDLE/DONE: start=1 moves to FETCH, sets base=0, clears done and block_count. start in any other state is ignored.
- FETCH: issues rom_addr=base+i for i=0..15 on consecutive cycles. The byte returned for address base+i is shifted into aes_in_block so that byte i lands at bits [127-8i:120-8i]. Leaves FETCH in the cycle the 16th byte is captured.
- ISSUE: aes_in_valid=1 with aes_in_block held stable until aes_in_ready=1. On the cycle where valid and ready are both high the block is transferred; the next state is WAIT.
- WAIT: aes_out_ready=1. On aes_out_valid=1 the sequencer latches aes_out_block and moves to DRAIN. aes_out_valid in any other state is not accepted (ready low).
- DRAIN: for i=0..15 on consecutive cycles, mem_we=1, mem_addr=base+i, mem_din=plaintext byte i (MSB byte first). After the 16th write, block_count increments and base increments by 16. If base+16 equals NUM_BYTES, go to DONE; otherwise go to FETCH.
- DONE: done=1, busy=0, and all strobes low.
- Fetch and AES processing are not overlapped; only one block is in flight.
- Address arithmetic is ADDR_W-bit unsigned. No wrap occurs because the NUM_BYTES check terminates the pass first.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE and every output is 0 on the following cycle, including rom_addr, aes_in_block, mem_addr, mem_din and block_count. This holds even mid-FETCH or mid-DRAIN; a partially written block is abandoned.
- start is sampled at cycle 0, and the first rom_addr=0 is driven at cycle 1.
- FETCH lasts 16+ROM_LAT cycles, and aes_in_valid rises in the next cycle.
- Handshake rule: aes_in_valid, once high, stays high with the data unchanged until it is accepted. It never depends combinationally on aes_in_ready.
- DRAIN lasts exactly 16 cycles, and mem_we is low outside DRAIN.
- Per-block cycles = 16+ROM_LAT + 1 (ISSUE, minimum) + core latency + 16.
- If start and rst=0 occur in the same cycle, reset wins.

## Structure
- Shared package aes_img_pkg holds BLOCK_BYTES=16, the FSM state encoding, and a byte-select helper for 128-bit blocks. The AES core uses the same helper.
- One natural sub-module, rom_block_fetcher: the address counter, the ROM_LAT delay line and the 128-bit shift register. It has a go pulse in and a block_valid strobe out.

## Test plan
- Single pass with NUM_BYTES=32, ROM holding bytes 0x00..0x1F, and the AES model set to identity with 3-cycle latency:
  - aes_in_block = 0x000102…0F, then 0x101112…1F.
  - Memory addresses 0..31 hold 0x00..0x1F.
  - done=1, block_count=2.
- Backpressure: aes_in_ready held low for 10 cycles:
  - aes_in_valid stays 1 and aes_in_block stays stable.
  - Exactly one transfer occurs.
- Known AES vector with a real core: ciphertext 0x69C4E0D86A7B0430D8CDB78070B4C55A under the FIPS-197 key writes 00 11 22 … FF to addresses 0..15.
- Reset asserted at the 8th DRAIN cycle:
  - All outputs are 0 on the next cycle.
  - After a new start the pass restarts at rom_addr=0.
- start pulsed while busy: ignored, so base and block_count are unaffected. start in DONE clears done and repeats the pass.
- ROM_LAT=2: the same data as the first scenario, with the FETCH phase measured at 18 cycles.
